pc_seq: RTL and testbench
=========================

PC_SEQ -- requirements
Module: pc_seq

Interface
REQ-001 Psize, 6, PC/branch-target width; SHALL match the program counter's Psize.
REQ-002 DB_CYCLES, 4, debounce stability count in cycles; used only when PCSEQ_DEBOUNCE_EN is defined; SHALL be >= 1.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 opcode  input  4  current instruction opcode.
REQ-006 target  input  Psize  absolute branch target from the instruction field.
REQ-007 pc_cur  input  Psize  current program counter value.
REQ-008 zero  input  1  ALU zero flag for the current instruction.
REQ-009 btn  input  1  asynchronous external step button, active-high.
REQ-010 PCincr  output  1  1 = PC + 1; 0 = PC loads Branchaddr.
REQ-011 Branchaddr  output  Psize  absolute load value for the PC.
REQ-012 w  output  1  register-file write enable.
REQ-013 sample_en  output  1  one-cycle pulse; datapath latches switch input.
REQ-014 waiting  output  1  high while in WAIT_PRESS or WAIT_RELEASE.
REQ-015 halted  output  1  high in HALT.

Function
REQ-016 Opcodes SHALL be: 0 NOP, 1 ADD, 2 ADDI, 3 SUB, 4 MULI, 5 BEQ, 6 JMP, 7 WAITB, 8 HALT; 9-15 decode as NOP.
REQ-017 States SHALL be RUN, WAIT_PRESS, WAIT_RELEASE, HALT; outputs SHALL be combinational from state, opcode, zero, pc_cur and the synchronized button btn_s.
REQ-018 "Hold" SHALL mean PCincr=0 and Branchaddr=pc_cur, leaving the PC unchanged at the next edge.
REQ-019 In RUN, opcodes 0-4 SHALL drive PCincr=1 and Branchaddr=target; w=1 for opcodes 1-4, w=0 for NOP.
REQ-020 In RUN, JMP SHALL drive PCincr=0 and Branchaddr=target, with w=0.
REQ-021 In RUN, BEQ with zero=1 SHALL behave as JMP; with zero=0 SHALL drive PCincr=1; w=0 in both cases.
REQ-022 In RUN, WAITB SHALL hold, drive w=0, and move to WAIT_PRESS.
REQ-023 In RUN, HALT SHALL hold, drive w=0, and move to HALT.
REQ-024 In WAIT_PRESS, with btn_s=0 the block SHALL hold.
REQ-025 In WAIT_PRESS, with btn_s=1 the block SHALL hold, pulse sample_en=1 for exactly that cycle, and move to WAIT_RELEASE.
REQ-026 In WAIT_RELEASE, with btn_s=1 the block SHALL hold.
REQ-027 In WAIT_RELEASE, with btn_s=0 the block SHALL drive PCincr=1, move to RUN, and pulse no second sample_en.
REQ-028 In HALT, the block SHALL hold indefinitely with w=0; only reset exits HALT.
REQ-029 btn SHALL pass through a 2-flop synchronizer before use, giving at least 2 cycles latency from btn to btn_s.
REQ-030 w and sample_en SHALL be 0 in every non-RUN cycle, except for the sample_en pulse defined in REQ-025.
REQ-031 Branchaddr wrap: no arithmetic is performed on Branchaddr; PC wrap-around from all-ones to 0 is owned by the PC.

Reset
REQ-032 While reset=0, the state SHALL be RUN, the synchronizer and debounce flops SHALL be 0, and waiting=0, halted=0, sample_en=0.
REQ-033 Reset asserted mid-wait or in HALT SHALL return the state to RUN immediately and asynchronously, with no sample_en pulse.
REQ-034 After reset release, the first edge SHALL decode opcode normally from RUN.

Configuration
REQ-035 With PCSEQ_DEBOUNCE_EN defined, btn_s SHALL change only after the synchronized button holds its new level for DB_CYCLES consecutive cycles; a counter resets on any change.
REQ-036 Without PCSEQ_DEBOUNCE_EN, btn_s SHALL equal the 2-flop synchronizer output directly, and no counter SHALL be built.

Verification
REQ-037 Reset low with opcode=1, then release -> first cycle PCincr=1, w=1; pc_cur 0->1.
REQ-038 opcode=5, target=0x2A: zero=1 -> PCincr=0, Branchaddr=0x2A; zero=0 -> PCincr=1, w=0.
REQ-039 opcode=7 at pc_cur=0x05; btn raised 10 cycles later and dropped 10 cycles after that -> PC stays 0x05, waiting=1, exactly one sample_en; PC=0x06 after release is seen.
REQ-040 opcode=8 -> halted=1, PC frozen for 100 cycles with btn toggling; reset low -> halted=0, state RUN.
REQ-041 PCSEQ_DEBOUNCE_EN, DB_CYCLES=4, in WAIT_PRESS: 2-cycle btn glitch -> no sample_en; 6-cycle press -> one sample_en.
REQ-042 reset asserted in WAIT_RELEASE -> waiting=0 immediately, no sample_en, RUN on release.

Source files
------------

// File: rtl/pc_seq.sv
// pc_seq: opcode sequencer driving PC increment/branch, register write and button-step handshake; PCSEQ_DEBOUNCE_EN adds a btn debouncer
module pc_seq #(
   parameter int Psize     = 6,
   parameter int DB_CYCLES = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       opcode,
   input  logic [Psize-1:0] target,
   input  logic [Psize-1:0] pc_cur,
   input  logic             zero,
   input  logic             btn,
   output logic             PCincr,
   output logic [Psize-1:0] Branchaddr,
   output logic             w,
   output logic             sample_en,
   output logic             waiting,
   output logic             halted
);
   typedef enum logic [1:0] {RUN, WAIT_PRESS, WAIT_RELEASE, HALT} state_t;
   state_t state, state_nxt;
   logic [1:0] sync;
   logic btn_s;
   if (DB_CYCLES < 1) begin : g_db_check
      $error("DB_CYCLES must be >= 1");
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) sync <= '0;
      else sync <= {sync[0], btn};
`ifdef PCSEQ_DEBOUNCE_EN
   localparam int CW = $clog2(DB_CYCLES + 1);
   logic [CW-1:0] cnt;
   logic btn_db;
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         cnt <= '0;
         btn_db <= 1'b0;
      end else if (sync[1] == btn_db) cnt <= '0;
      else if (cnt == CW'(DB_CYCLES - 1)) begin
         cnt <= '0;
         btn_db <= sync[1];
      end else cnt <= cnt + 1'b1;
   assign btn_s = btn_db;
`else
   assign btn_s = sync[1];
`endif
   always_ff @(posedge clk or negedge reset)
      if (!reset) state <= RUN;
      else state <= state_nxt;
   always_comb begin
      state_nxt = state;
      PCincr = 1'b0;
      Branchaddr = pc_cur;
      w = 1'b0;
      sample_en = 1'b0;
      case (state)
         RUN:
            case (opcode)
               4'd5: begin
                  PCincr = !zero;
                  Branchaddr = target;
               end
               4'd6: Branchaddr = target;
               4'd7: state_nxt = WAIT_PRESS;
               4'd8: state_nxt = HALT;
               default: begin
                  PCincr = 1'b1;
                  Branchaddr = target;
                  w = opcode inside {[4'd1:4'd4]};
               end
            endcase
         WAIT_PRESS:
            if (btn_s) begin
               sample_en = 1'b1;
               state_nxt = WAIT_RELEASE;
            end
         WAIT_RELEASE:
            if (!btn_s) begin
               PCincr = 1'b1;
               state_nxt = RUN;
            end
         default: ;
      endcase
   end
   assign waiting = (state == WAIT_PRESS) || (state == WAIT_RELEASE);
   assign halted  = (state == HALT);
endmodule

// File: tb/tb_pc_seq.sv
// tb_pc_seq: table vectors, directed wait/halt/reset sequences and a randomized run against a rule-level model of pc_seq
module tb_pc_seq;
   localparam int P  = 6;
   localparam int DB = 4;
`ifdef PCSEQ_DEBOUNCE_EN
   localparam int LAT = 1 + DB;
`else
   localparam int LAT = 1;
`endif
   localparam logic [1:0] M_RUN = 2'd0, M_WP = 2'd1, M_WR = 2'd2, M_HALT = 2'd3;
   logic clk = 1'b0, reset = 1'b0, zero = 1'b0, btn = 1'b0, track = 1'b0;
   logic [3:0] opcode = '0;
   logic [P-1:0] target = '0, pc_tab = '0, pc_model = '0, pc_cur, Branchaddr;
   logic PCincr, w, sample_en, waiting, halted;
   int checks = 0, errors = 0, se_cnt = 0;
   pc_seq #(.Psize(P), .DB_CYCLES(DB)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .target(target), .pc_cur(pc_cur),
      .zero(zero), .btn(btn), .PCincr(PCincr), .Branchaddr(Branchaddr), .w(w),
      .sample_en(sample_en), .waiting(waiting), .halted(halted)
   );
   always #5 clk = ~clk;
   assign pc_cur = track ? pc_model : pc_tab;
   // the PC register the sequencer steers
   always @(posedge clk) pc_model <= !track ? pc_tab : PCincr ? pc_model + 1'b1 : Branchaddr;
   always @(negedge clk) if (sample_en === 1'b1) se_cnt++;
   typedef struct {
      logic [3:0] op; logic z; logic [P-1:0] tgt; logic [P-1:0] pc;
      logic incr; logic [P-1:0] addr; logic wr;
   } vec_t;
   typedef struct packed {
      logic incr; logic [P-1:0] addr; logic wr; logic se; logic [1:0] nxt;
   } exp_t;
   vec_t tv[12];
   exp_t e;
   logic [LAT:0] hist;
   logic [1:0] mode;
   logic [P-1:0] p0;
   int base, bad, bh, hc;
   logic [3:0] op;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   function automatic exp_t model(input logic [1:0] m, input logic [3:0] o, input logic z,
                                  input logic [P-1:0] tgt, input logic [P-1:0] pc, input logic bs);
      exp_t r;
      logic run, hold;
      run  = (m == M_RUN);
      hold = !run || o == 4'd7 || o == 4'd8;
      r.wr = run && o >= 4'd1 && o <= 4'd4;
      r.se = (m == M_WP) && bs;
      r.incr = (m == M_WR && !bs) || (!hold && !(o == 4'd6 || (o == 4'd5 && z)));
      r.addr = hold ? pc : tgt;
      r.nxt = m == M_RUN ? (o == 4'd7 ? M_WP : o == 4'd8 ? M_HALT : M_RUN) :
              m == M_WP  ? (bs ? M_WR : M_WP) :
              m == M_WR  ? (bs ? M_WR : M_RUN) : M_HALT;
      return r;
   endfunction
   initial begin
      tv[0]  = '{4'd0,  1'b0, 6'h11, 6'h05, 1'b1, 6'h11, 1'b0};
      tv[1]  = '{4'd1,  1'b0, 6'h12, 6'h06, 1'b1, 6'h12, 1'b1};
      tv[2]  = '{4'd2,  1'b1, 6'h13, 6'h07, 1'b1, 6'h13, 1'b1};
      tv[3]  = '{4'd3,  1'b0, 6'h3F, 6'h3F, 1'b1, 6'h3F, 1'b1};
      tv[4]  = '{4'd4,  1'b1, 6'h00, 6'h3F, 1'b1, 6'h00, 1'b1};
      tv[5]  = '{4'd5,  1'b1, 6'h2A, 6'h10, 1'b0, 6'h2A, 1'b0};
      tv[6]  = '{4'd5,  1'b0, 6'h2A, 6'h10, 1'b1, 6'h2A, 1'b0};
      tv[7]  = '{4'd6,  1'b0, 6'h00, 6'h20, 1'b0, 6'h00, 1'b0};
      tv[8]  = '{4'd6,  1'b1, 6'h3F, 6'h01, 1'b0, 6'h3F, 1'b0};
      tv[9]  = '{4'd9,  1'b1, 6'h15, 6'h02, 1'b1, 6'h15, 1'b0};
      tv[10] = '{4'd15, 1'b0, 6'h16, 6'h03, 1'b1, 6'h16, 1'b0};
      tv[11] = '{4'd12, 1'b1, 6'h01, 6'h00, 1'b1, 6'h01, 1'b0};
      // reset held: WAITB and a pressed button must not leave RUN
      opcode = 4'd7;
      btn = 1'b1;
      repeat (3) step();
      chk("rst_waiting", waiting, 0);
      chk("rst_halted", halted, 0);
      chk("rst_sample_en", sample_en, 0);
      opcode = 4'd1;
      btn = 1'b0;
      step();
      chk("rst_incr", PCincr, 1);
      track = 1'b1;
      reset = 1'b1;
      @(negedge clk);
      chk("first_incr", PCincr, 1);
      chk("first_w", w, 1);
      step();
      chk("first_pc", pc_cur, 1);
      track = 1'b0;
      for (int i = 0; i < 12; i++) begin
         opcode = tv[i].op; zero = tv[i].z; target = tv[i].tgt; pc_tab = tv[i].pc;
         @(negedge clk);
         chk($sformatf("tv%0d_incr", i), PCincr, tv[i].incr);
         chk($sformatf("tv%0d_w", i), w, tv[i].wr);
         if (!tv[i].incr || tv[i].op <= 4'd4) chk($sformatf("tv%0d_addr", i), Branchaddr, tv[i].addr);
         step();
      end
      // WAITB handshake at pc 0x05
      pc_tab = 6'h05;
      opcode = 4'd0;
      step();
      track = 1'b1;
      opcode = 4'd7;
      base = se_cnt;
      repeat (10) step();
      chk("wb_waiting", waiting, 1);
      chk("wb_pc", pc_cur, 6'h05);
      btn = 1'b1;
      repeat (10) step();
      chk("wb_press_waiting", waiting, 1);
      chk("wb_press_pc", pc_cur, 6'h05);
      chk("wb_press_se", se_cnt - base, 1);
      btn = 1'b0;
      for (int i = 0; i < 20 && waiting; i++) step();
      chk("wb_release_exit", waiting, 0);
      chk("wb_release_pc", pc_cur, 6'h06);
      chk("wb_release_se", se_cnt - base, 1);
      // HALT freezes PC regardless of button activity
      opcode = 4'd8;
      reset = 1'b0;
      step();
      reset = 1'b1;
      step();
      chk("halt_halted", halted, 1);
      p0 = pc_cur;
      base = se_cnt;
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         btn = ((i / 3) % 2) != 0;
         step();
         if (!halted || pc_cur !== p0 || w || sample_en) bad++;
      end
      chk("halt_frozen_bad", bad, 0);
      chk("halt_se", se_cnt - base, 0);
      btn = 1'b0;
      reset = 1'b0;
      #1;
      chk("halt_rst_halted", halted, 0);
      step();
      reset = 1'b1;
      opcode = 4'd0;
      @(negedge clk);
      chk("halt_rst_run_incr", PCincr, 1);
      // reset asserted in WAIT_RELEASE
      step();
      opcode = 4'd7;
      step();
      chk("wr_enter", waiting, 1);
      base = se_cnt;
      btn = 1'b1;
      for (int i = 0; i < 20 && se_cnt == base; i++) step();
      chk("wr_press_se", se_cnt - base, 1);
      chk("wr_waiting", waiting, 1);
      #3;
      reset = 1'b0;
      #1;
      chk("wr_rst_waiting", waiting, 0);
      chk("wr_rst_se", sample_en, 0);
      repeat (2) step();
      reset = 1'b1;
      btn = 1'b0;
      opcode = 4'd0;
      @(negedge clk);
      chk("wr_rel_waiting", waiting, 0);
      chk("wr_rel_incr", PCincr, 1);
      chk("wr_rel_se", se_cnt - base, 1);
`ifdef PCSEQ_DEBOUNCE_EN
      step();
      opcode = 4'd7;
      step();
      chk("db_waiting", waiting, 1);
      base = se_cnt;
      btn = 1'b1;
      repeat (2) step();
      btn = 1'b0;
      repeat (12) step();
      chk("db_glitch_se", se_cnt - base, 0);
      chk("db_glitch_waiting", waiting, 1);
      btn = 1'b1;
      repeat (6) step();
      btn = 1'b0;
      repeat (12) step();
      chk("db_press_se", se_cnt - base, 1);
`endif
      // randomized run against the rule model
      step();
      reset = 1'b0;
      track = 1'b1;
      btn = 1'b0;
      mode = M_RUN;
      hist = '0;
      bh = 8;
      hc = 0;
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         e = model(mode, opcode, zero, target, pc_cur, hist[LAT]);
         chk("rnd_incr", PCincr, e.incr);
         chk("rnd_w", w, e.wr);
         chk("rnd_se", sample_en, e.se);
         chk("rnd_waiting", waiting, mode == M_WP || mode == M_WR);
         chk("rnd_halted", halted, mode == M_HALT);
         if (!e.incr) chk("rnd_addr", Branchaddr, e.addr);
         @(posedge clk);
         mode = reset ? e.nxt : M_RUN;
         hist = {hist[LAT-1:0], reset ? btn : 1'b0};
         if (mode == M_HALT) hc++;
         #1;
         op = 4'($urandom_range(0, 15));
         if (op == 4'd8 && $urandom_range(0, 3) != 0) op = 4'd0;
         opcode = op;
         zero = 1'($urandom_range(0, 1));
         target = 6'($urandom_range(0, 63));
         bh--;
         if (bh == 0) begin
            btn = ~btn;
            bh = $urandom_range(6, 12);
         end
         if (!reset) begin
            reset = 1'b1;
            bh = $urandom_range(6, 12);
         end else if (hc > 5 || $urandom_range(0, 299) == 0) begin
            reset = 1'b0;
            mode = M_RUN;
            hist = '0;
            hc = 0;
         end
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
